// File: rtl/mac_array_ctrl_pkg.sv
// Shared definitions for the MAC array sequencer: FSM states, per-row
// instruction codes, SRAM read latency and the DRAIN watchdog limit.
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } ctrl_state_e;

  // Per-row instruction: bit1 execute, bit0 kernel load
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Cycles from SRAM read enable to data at row 0
  localparam int unsigned SRAM_RD_LAT = 1;

  // DRAIN cycles tolerated before the watchdog forces completion
  function automatic int unsigned wdog_limit(input int unsigned rows, input int unsigned cols);
    return 2 * (rows + cols) + 4;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_inst_skew.sv
// inst_skew: 2-bit instruction delay line. Tap s carries the input
// delayed by s+1 cycles; the line shifts every cycle, so idle zeros
// flow in behind the last instruction.
module inst_skew #(
  parameter int unsigned stages = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            inst_in,
  output logic [2*stages-1:0]   taps
);

  // Shift register: stage 0 takes the new code, stage s takes stage s-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else begin
      taps[1:0] <= inst_in;
      for (int unsigned s = 1; s < stages; s++) begin
        taps[2*s +: 2] <= taps[2*(s-1) +: 2];
      end
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequencer for the 2D MAC array. One start runs
// weight load, a row-length gap, execute, drain and a done pulse,
// driving skewed per-row instructions, SRAM reads and output-FIFO strobes.
// Optional feature: define MAC_CTRL_WDOG_EN to enable the DRAIN watchdog
// (sticky err, forced completion); otherwise err is tied low.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned cnt_bw = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic [cnt_bw-1:0] num_ker,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [col-1:0]    valid_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mode_sel,
  output logic [2*row-1:0]  inst_w,
  output logic              w_rd_en,
  output logic [cnt_bw-1:0] w_addr,
  output logic              x_rd_en,
  output logic [cnt_bw-1:0] x_addr,
  output logic [col-1:0]    ofifo_wr
);

  localparam int unsigned SKEW_STAGES = row + SRAM_RD_LAT - 1;
  localparam int unsigned GAP_W       = $clog2(row + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(row - 1);

  ctrl_state_e             state_q, state_d;
  logic [cnt_bw-1:0]       num_ker_q, num_act_q;
  logic [cnt_bw-1:0]       out_cnt, out_cnt_nxt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [1:0]              base_inst;
  logic [2*SKEW_STAGES-1:0] skew_taps;
  logic                    drain_hit;
  logic                    wdog_to;

  // Completion includes the bottom-row valid arriving this cycle so done
  // follows the final output by exactly one cycle
  assign out_cnt_nxt = out_cnt + cnt_bw'(valid_last[col-1]);
  assign drain_hit   = (out_cnt_nxt == num_act_q);

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign ofifo_wr = valid_last & {col{busy}};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-phase SRAM enables / base instruction
  always_comb begin
    state_d   = state_q;
    base_inst = INST_IDLE;
    w_rd_en   = 1'b0;
    x_rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_ker == '0) ? S_GAP : S_LOAD;
      end
      S_LOAD: begin
        base_inst = INST_LOAD;
        w_rd_en   = 1'b1;
        if (w_addr == num_ker_q - cnt_bw'(1)) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = (num_act_q == '0) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        base_inst = INST_EXEC;
        x_rd_en   = 1'b1;
        if (x_addr == num_act_q - cnt_bw'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_hit || wdog_to) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operation parameters, addresses, gap and output counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sel  <= 1'b0;
      num_ker_q <= '0;
      num_act_q <= '0;
      w_addr    <= '0;
      x_addr    <= '0;
      gap_cnt   <= '0;
      out_cnt   <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        mode_sel  <= mode_in;
        num_ker_q <= num_ker;
        num_act_q <= num_act;
        out_cnt   <= '0;
        w_addr    <= '0;
      end else if (state_q != S_IDLE) begin
        out_cnt <= out_cnt_nxt;
      end

      if (state_q == S_LOAD && state_d == S_LOAD) w_addr <= w_addr + cnt_bw'(1);

      if (state_q == S_GAP && state_d == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                      gap_cnt <= '0;

      if (state_q == S_GAP && state_d == S_EXEC)       x_addr <= '0;
      else if (state_q == S_EXEC && state_d == S_EXEC) x_addr <= x_addr + cnt_bw'(1);
    end
  end

`ifdef MAC_CTRL_WDOG_EN
  localparam int unsigned WDOG_LIMIT = wdog_limit(row, col);
  localparam int unsigned WDOG_W     = $clog2(WDOG_LIMIT);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              err_q;

  assign wdog_to = (state_q == S_DRAIN) && !drain_hit &&
                   (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
  assign err     = err_q;

  // DRAIN cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == S_DRAIN) wdog_cnt <= wdog_cnt + WDOG_W'(1);
      else                    wdog_cnt <= '0;
      if (wdog_to) err_q <= 1'b1;
    end
  end
`else
  assign wdog_to = 1'b0;
  assign err     = 1'b0;
`endif

  inst_skew #(
    .stages (SKEW_STAGES)
  ) u_inst_skew (
    .clk     (clk),
    .reset   (reset),
    .inst_in (base_inst),
    .taps    (skew_taps)
  );

  // Row r takes the tap delayed by SRAM latency plus r cycles
  assign inst_w = skew_taps[2*SKEW_STAGES-1 -: 2*row];

endmodule
